// File: rtl/scsi_io_arb_if.sv
// Bus bundle between two SCSI targets, the arbiter and the SD/io controller.
// Targets read sd_buff_addr/sd_buff_dout straight off this bundle, so the broadcast is a plain wire fan-out.
interface scsi_io_arb_if;
    logic [31:0] t0_lba;
    logic [31:0] t1_lba;
    logic        t0_rd;
    logic        t0_wr;
    logic        t1_rd;
    logic        t1_wr;
    logic        t0_ack;
    logic        t1_ack;
    logic [7:0]  t0_buff_din;
    logic [7:0]  t1_buff_din;
    logic        t0_buff_wr;
    logic        t1_buff_wr;
    logic [31:0] sd_lba;
    logic        sd_rd;
    logic        sd_wr;
    logic        sd_ack;
    logic [8:0]  sd_buff_addr;
    logic [7:0]  sd_buff_dout;
    logic [7:0]  sd_buff_din;
    logic        sd_buff_wr;
    logic        grant_id;
    logic        busy;
    logic        timeout_err;

    modport slave (
        input  t0_lba, t1_lba, t0_rd, t0_wr, t1_rd, t1_wr,
        input  t0_buff_din, t1_buff_din, sd_ack, sd_buff_wr,
        output t0_ack, t1_ack, t0_buff_wr, t1_buff_wr,
        output sd_lba, sd_rd, sd_wr, sd_buff_din, grant_id, busy, timeout_err
    );

    modport master (
        output t0_lba, t1_lba, t0_rd, t0_wr, t1_rd, t1_wr,
        output t0_buff_din, t1_buff_din, sd_ack, sd_buff_wr, sd_buff_addr, sd_buff_dout,
        input  t0_ack, t1_ack, t0_buff_wr, t1_buff_wr,
        input  sd_lba, sd_rd, sd_wr, sd_buff_din, grant_id, busy, timeout_err
    );
endinterface

// File: rtl/scsi_io_arb.sv
// Round-robin arbiter sharing one SD/io controller between two SCSI targets,
// with a per-transaction watchdog that aborts a stalled controller handshake.
module scsi_io_arb #(
    parameter logic [23:0] TIMEOUT = 24'd10000000
) (
    input  logic         clk,
    input  logic         rst_n,
    scsi_io_arb_if.slave bus
);

    typedef enum logic [1:0] {IDLE, REQ, XFER, ABORT} state_t;

    state_t      state, state_nx;
    logic        gnt, gnt_nx;
    logic        last, last_nx;
    logic        op_wr, op_wr_nx;
    logic [31:0] lba, lba_nx;
    logic [23:0] cnt, cnt_nx;
    logic        pend0, pend1, pick;
    logic        active, abort;

    assign pend0 = bus.t0_rd | bus.t0_wr;
    assign pend1 = bus.t1_rd | bus.t1_wr;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            gnt   <= 1'b0;
            last  <= 1'b1;
            op_wr <= 1'b0;
            lba   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            gnt   <= gnt_nx;
            last  <= last_nx;
            op_wr <= op_wr_nx;
            lba   <= lba_nx;
            cnt   <= cnt_nx;
        end
    end

    // NOTE: every signal gets a hold default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_nx = state;
        gnt_nx   = gnt;
        last_nx  = last;
        op_wr_nx = op_wr;
        lba_nx   = lba;
        cnt_nx   = cnt;
        pick     = pend1;
        unique case (state)
            IDLE: begin
                if (pend0 && pend1) pick = ~last;
                if (pend0 || pend1) begin
                    gnt_nx   = pick;
                    lba_nx   = pick ? bus.t1_lba : bus.t0_lba;
                    op_wr_nx = pick ? bus.t1_wr : bus.t0_wr;
                    cnt_nx   = '0;
                    state_nx = REQ;
                end
            end
            REQ, XFER: begin
                // Watchdog wins over a handshake step landing on the same edge.
                if (cnt == TIMEOUT - 24'd1) begin
                    state_nx = ABORT;
                end else begin
                    cnt_nx = cnt + 24'd1;
                    if (state == REQ && bus.sd_ack) begin
                        state_nx = XFER;
                    end else if (state == XFER && !bus.sd_ack) begin
                        state_nx = IDLE;
                        last_nx  = gnt;
                    end
                end
            end
            ABORT: begin
                state_nx = IDLE;
                last_nx  = gnt;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign active = (state == REQ) || (state == XFER);
    assign abort  = (state == ABORT);

    // Strobes are combinational off state so reset kills them without waiting for an edge.
    assign bus.t0_ack      = ((bus.sd_ack & active) | abort) & ~gnt;
    assign bus.t1_ack      = ((bus.sd_ack & active) | abort) &  gnt;
    assign bus.t0_buff_wr  = bus.sd_buff_wr & active & ~gnt;
    assign bus.t1_buff_wr  = bus.sd_buff_wr & active &  gnt;
    assign bus.sd_rd       = (state == REQ) & ~op_wr;
    assign bus.sd_wr       = (state == REQ) &  op_wr;
    assign bus.sd_lba      = lba;
    assign bus.sd_buff_din = gnt ? bus.t1_buff_din : bus.t0_buff_din;
    assign bus.grant_id    = gnt;
    assign bus.busy        = (state != IDLE);
    assign bus.timeout_err = abort;

endmodule

// File: doc/scsi_io_arb.md
SCSI_IO_ARB -- requirements
Module: scsi_io_arb

Interface
REQ-001 The module SHALL have parameter TIMEOUT, default 24'd10000000, the watchdog limit in clk cycles per transaction.
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 The reset SHALL be rst_n  input  1  asynchronous, active-low reset.
REQ-004 t0_lba / t1_lba  input  32  block address from target 0 / 1.
REQ-005 t0_rd, t0_wr / t1_rd, t1_wr  input  1 each  level read/write requests, held until that target's ack.
REQ-006 t0_ack / t1_ack  output  1  io_ack to target 0 / 1.
REQ-007 t0_buff_din / t1_buff_din  input  8  sector byte from each target's buffer_out.
REQ-008 t0_buff_wr / t1_buff_wr  output  1  gated buffer write strobe per target.
REQ-009 sd_lba  output  32  latched address of granted transaction.
REQ-010 sd_rd, sd_wr  output  1  requests to SD/io controller.
REQ-011 sd_ack  input  1  io controller acknowledge, high for the whole sector transfer.
REQ-012 sd_buff_addr  input  9  byte address; SHALL be broadcast unmodified to both targets.
REQ-013 sd_buff_dout  input  8  read data; SHALL be broadcast unmodified to both targets.
REQ-014 sd_buff_din  output  8  write data muxed from the granted target.
REQ-015 sd_buff_wr  input  1  read-data strobe from io controller.
REQ-016 grant_id  output  1  index of current/last granted target.
REQ-017 busy  output  1  high in any state other than IDLE.
REQ-018 timeout_err  output  1  one-cycle pulse on watchdog abort.

Function
REQ-019 The FSM SHALL have states IDLE, REQ, XFER and ABORT.
REQ-020 IDLE: a target is pending when rd|wr is high; if one is pending, it SHALL be granted; if both, the one not equal to last_served SHALL be granted (round robin).
REQ-021 IDLE->REQ on grant: latch grant_id, sd_lba <= that target's lba, and op (wr takes precedence over rd when both are high on one target); sd_rd/sd_wr become 1 on the next edge (one-cycle request latency).
REQ-022 REQ: sd_rd (op=read) or sd_wr (op=write) SHALL be held high; on sampling sd_ack=1, go to XFER and deassert sd_rd/sd_wr on that edge.
REQ-023 XFER: on sampling sd_ack=0, go to IDLE and set last_served <= grant_id; a new grant is possible on the following cycle.
REQ-024 tN_ack SHALL equal sd_ack AND (state in REQ/XFER) AND grant_id==N; it is combinational and forced to 0 for the non-granted target.
REQ-025 tN_buff_wr SHALL equal sd_buff_wr gated the same way as tN_ack.
REQ-026 sd_buff_din SHALL be t[grant_id]_buff_din combinationally, with no added latency, so the target's one-cycle buffer read timing is preserved.
REQ-027 sd_lba, grant_id and op SHALL NOT change outside IDLE, even if the requester's lba changes.
REQ-028 Watchdog: a 24-bit counter clears on entering REQ and increments in REQ/XFER; reaching TIMEOUT-1 SHALL go to ABORT.
REQ-029 ABORT (one cycle): sd_rd=sd_wr=0; tN_ack=1 for the granted target only; timeout_err=1; then IDLE, last_served <= grant_id.
REQ-030 An sd_ack arriving while in IDLE SHALL be ignored: no target ack and no state change.
REQ-031 A request that drops in REQ before sd_ack SHALL NOT abort the transaction; the arbiter completes it normally.

Reset
REQ-032 While rst_n=0, all of the following SHALL hold asynchronously: state=IDLE; sd_rd=sd_wr=0; sd_lba=0; grant_id=0; last_served=1 (target 0 wins first tie); busy=0; timeout_err=0; counter=0; t0_ack=t1_ack=0.
REQ-033 A reset mid-transaction SHALL drop sd_rd/sd_wr immediately, with no completion ack to either target.

Verification
REQ-034 Single read: t0_rd=1, t0_lba=0x100 -> sd_rd=1 and sd_lba=0x100 one cycle later; sd_ack high for 512 cycles -> t0_ack mirrors it and t0_buff_wr follows sd_buff_wr; t1 strobes stay 0.
REQ-035 Tie after reset: t0_rd and t1_wr rise in the same cycle -> t0 is served first, then t1 with sd_wr=1; the next tie serves t1 first.
REQ-036 Write mux: t1 granted with sd_wr=1 and t1_buff_din=0xA5 -> sd_buff_din=0xA5 in the same cycle; t0_buff_din=0x3C is not visible.
REQ-037 Timeout: TIMEOUT=16, t1_rd=1, sd_ack held 0 -> ABORT after 16 cycles; t1_ack=1 and timeout_err=1 for one cycle; a late sd_ack in IDLE is ignored.
REQ-038 Reset mid-XFER: rst_n=0 while sd_ack=1 -> sd_rd=0, busy=0 and t0_ack=0 immediately; after release, a pending t1 request is granted normally.
